// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares a single external bus between an instruction-fetch port and a
//   load/store port. One access is in flight at a time. Ties between the two
//   ports alternate, starting with the data port after reset. An access that
//   sees no bus_ack for TIMEOUT strobe cycles is completed with bus_error.
//   Every output comes straight from a register.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   inst_*              : fetch request (address, req, translation fault),
//                         read data, and a done pulse
//   data_*              : load/store request (address, req, fault, we,
//                         byte lanes, write data), read data, and a done pulse
//   bus_error           : pulses together with a done when that access timed out
//   bus_address/read/write/byte_sel/wdata : bus master outputs
//   bus_rdata, bus_ack  : bus slave responses
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_address,
  input  logic        inst_req,
  input  logic        inst_exp,
  input  logic [31:0] data_address,
  input  logic        data_req,
  input  logic        data_exp,
  input  logic        data_we,
  input  logic [3:0]  data_byte_sel,
  input  logic [31:0] data_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        bus_error,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byte_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  typedef enum logic {GNT_INST, GNT_DATA} gnt_t;

  // Compared against a 9-bit incremented count so TIMEOUT = 255 cannot wrap.
  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t      state, state_d;
  gnt_t        grant, grant_d;
  gnt_t        last_grant, last_grant_d;
  logic        we_q, we_d;
  logic [7:0]  count, count_d;
  logic [8:0]  count_inc;
  logic        iq, dq, pick_data;

  logic [31:0] inst_rdata_d, data_rdata_d, bus_address_d, bus_wdata_d;
  logic [3:0]  bus_byte_sel_d;
  logic        inst_done_d, data_done_d, bus_error_d, bus_read_d, bus_write_d;

  assign iq        = inst_req & ~inst_exp;
  assign dq        = data_req & ~data_exp;
  // Data wins when it is alone, or on a tie when inst was granted last.
  assign pick_data = dq & (~iq | (last_grant == GNT_INST));
  assign count_inc = {1'b0, count} + 9'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d        = state;
    grant_d        = grant;
    last_grant_d   = last_grant;
    we_d           = we_q;
    count_d        = count;
    inst_rdata_d   = inst_rdata;
    data_rdata_d   = data_rdata;
    bus_address_d  = bus_address;
    bus_byte_sel_d = bus_byte_sel;
    bus_wdata_d    = bus_wdata;
    inst_done_d    = 1'b0;
    data_done_d    = 1'b0;
    bus_error_d    = 1'b0;
    bus_read_d     = 1'b0;
    bus_write_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (iq || dq) begin
          state_d = ACC;
          count_d = '0;
          if (pick_data) begin
            grant_d        = GNT_DATA;
            last_grant_d   = GNT_DATA;
            we_d           = data_we;
            bus_address_d  = data_address;
            bus_byte_sel_d = data_byte_sel;
            bus_wdata_d    = data_wdata;
            bus_read_d     = ~data_we;
            bus_write_d    = data_we;
          end else begin
            grant_d        = GNT_INST;
            last_grant_d   = GNT_INST;
            we_d           = 1'b0;
            bus_address_d  = inst_address;
            bus_byte_sel_d = 4'hF;
            bus_wdata_d    = '0;
            bus_read_d     = 1'b1;
          end
        end
      end

      ACC: begin
        if (bus_ack || (count_inc == TIMEOUT_W)) begin
          // Either completion or timeout: strobe drops, done fires next cycle.
          state_d     = RESP;
          bus_error_d = ~bus_ack;
          inst_done_d = (grant == GNT_INST);
          data_done_d = (grant == GNT_DATA);
          if (!we_q) begin
            if (grant == GNT_INST) inst_rdata_d = bus_ack ? bus_rdata : '0;
            else                   data_rdata_d = bus_ack ? bus_rdata : '0;
          end
        end else begin
          count_d     = count_inc[7:0];
          bus_read_d  = ~we_q;
          bus_write_d = we_q;
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    if (rst) begin
      state        <= IDLE;
      grant        <= GNT_INST;
      last_grant   <= GNT_INST;
      we_q         <= 1'b0;
      count        <= '0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      bus_address  <= '0;
      bus_byte_sel <= '0;
      bus_wdata    <= '0;
      inst_done    <= 1'b0;
      data_done    <= 1'b0;
      bus_error    <= 1'b0;
      bus_read     <= 1'b0;
      bus_write    <= 1'b0;
    end else begin
      state        <= state_d;
      grant        <= grant_d;
      last_grant   <= last_grant_d;
      we_q         <= we_d;
      count        <= count_d;
      inst_rdata   <= inst_rdata_d;
      data_rdata   <= data_rdata_d;
      bus_address  <= bus_address_d;
      bus_byte_sel <= bus_byte_sel_d;
      bus_wdata    <= bus_wdata_d;
      inst_done    <= inst_done_d;
      data_done    <= data_done_d;
      bus_error    <= bus_error_d;
      bus_read     <= bus_read_d;
      bus_write    <= bus_write_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter (TIMEOUT = 4). Inputs change and outputs
//   are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] inst_address;
  logic        inst_req;
  logic        inst_exp;
  logic [31:0] data_address;
  logic        data_req;
  logic        data_exp;
  logic        data_we;
  logic [3:0]  data_byte_sel;
  logic [31:0] data_wdata;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_error;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byte_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_address (inst_address),
    .inst_req     (inst_req),
    .inst_exp     (inst_exp),
    .data_address (data_address),
    .data_req     (data_req),
    .data_exp     (data_exp),
    .data_we      (data_we),
    .data_byte_sel(data_byte_sel),
    .data_wdata   (data_wdata),
    .inst_rdata   (inst_rdata),
    .inst_done    (inst_done),
    .data_rdata   (data_rdata),
    .data_done    (data_done),
    .bus_error    (bus_error),
    .bus_address  (bus_address),
    .bus_read     (bus_read),
    .bus_write    (bus_write),
    .bus_byte_sel (bus_byte_sel),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        is_data;
    logic [31:0] exp_addr;

    rst = 1'b1;
    inst_address = '0; inst_req = 1'b0; inst_exp = 1'b0;
    data_address = '0; data_req = 1'b0; data_exp = 1'b0;
    data_we = 1'b0; data_byte_sel = 4'h0; data_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_bus_read",    32'(bus_read),  32'd0);
    check("rst_bus_write",   32'(bus_write), 32'd0);
    check("rst_inst_done",   32'(inst_done), 32'd0);
    check("rst_data_done",   32'(data_done), 32'd0);
    check("rst_bus_error",   32'(bus_error), 32'd0);
    check("rst_inst_rdata",  inst_rdata,     32'd0);
    check("rst_data_rdata",  data_rdata,     32'd0);
    check("rst_bus_address", bus_address,    32'd0);
    rst = 1'b0;
    tick();

    // Single fetch, ack on the first strobe cycle
    inst_address = 32'h1FC0_0000; inst_req = 1'b1;
    tick();
    check("f_bus_read",     32'(bus_read),     32'd1);
    check("f_bus_write",    32'(bus_write),    32'd0);
    check("f_bus_address",  bus_address,       32'h1FC0_0000);
    check("f_bus_byte_sel", 32'(bus_byte_sel), 32'hF);
    check("f_early_done",   32'(inst_done),    32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h3C08_0001;
    tick();
    check("f_strobe_drop",  32'(bus_read),  32'd0);
    check("f_inst_done",    32'(inst_done), 32'd1);
    check("f_data_done",    32'(data_done), 32'd0);
    check("f_bus_error",    32'(bus_error), 32'd0);
    check("f_inst_rdata",   inst_rdata,     32'h3C08_0001);
    bus_ack = 1'b0; inst_req = 1'b0;
    tick();
    check("f_done_oneshot", 32'(inst_done), 32'd0);
    check("f_rdata_hold",   inst_rdata,     32'h3C08_0001);

    // Load, then a store that must leave data_rdata alone
    data_address = 32'h0000_0200; data_we = 1'b0; data_byte_sel = 4'hF; data_req = 1'b1;
    tick();
    check("ld_bus_read", 32'(bus_read), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    check("ld_data_done",  32'(data_done), 32'd1);
    check("ld_data_rdata", data_rdata,     32'h1234_5678);
    bus_ack = 1'b0; data_req = 1'b0;
    tick();

    data_address = 32'h0000_0104; data_we = 1'b1; data_byte_sel = 4'b0011;
    data_wdata = 32'hDEAD_BEEF; data_req = 1'b1;
    tick();
    check("st_bus_write",    32'(bus_write),    32'd1);
    check("st_bus_read",     32'(bus_read),     32'd0);
    check("st_bus_address",  bus_address,       32'h0000_0104);
    check("st_bus_byte_sel", 32'(bus_byte_sel), 32'h3);
    check("st_bus_wdata",    bus_wdata,         32'hDEAD_BEEF);
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_C0DE;
    tick();
    check("st_write_drop", 32'(bus_write), 32'd0);
    check("st_data_done",  32'(data_done), 32'd1);
    check("st_rdata_hold", data_rdata,     32'h1234_5678);
    bus_ack = 1'b0; data_req = 1'b0; data_we = 1'b0; data_byte_sel = 4'hF;
    tick();

    // Fresh reset so the tie-break starts with data
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Both ports held, ack latency 2: expect data, inst, data, inst
    inst_address = 32'h0040_0000; inst_req = 1'b1;
    data_address = 32'h0000_1000; data_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      is_data  = (k % 2 == 0);
      exp_addr = is_data ? 32'h0000_1000 + 32'(4 * (k / 2))
                         : 32'h0040_0000 + 32'(4 * (k / 2));
      tick();
      check($sformatf("alt%0d_addr", k),   bus_address,       exp_addr);
      check($sformatf("alt%0d_read1", k),  32'(bus_read),     32'd1);
      tick();
      check($sformatf("alt%0d_read2", k),  32'(bus_read),     32'd1);
      bus_ack = 1'b1; bus_rdata = 32'hA000_0000 + 32'(k);
      tick();
      bus_ack = 1'b0;
      check($sformatf("alt%0d_ddone", k),  32'(data_done),    32'(is_data));
      check($sformatf("alt%0d_idone", k),  32'(inst_done),    32'(!is_data));
      check($sformatf("alt%0d_rdata", k),  is_data ? data_rdata : inst_rdata,
            32'hA000_0000 + 32'(k));
      if (is_data) begin
        if (k == 0) data_address = 32'h0000_1004; else data_req = 1'b0;
      end else begin
        if (k == 1) inst_address = 32'h0040_0004; else inst_req = 1'b0;
      end
      tick();
    end
    tick();
    check("alt_idle_read", 32'(bus_read), 32'd0);

    // Timeout: no ack, TIMEOUT = 4
    data_address = 32'h0000_2000; data_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_strobe%0d", i), 32'(bus_read),  32'd1);
      check($sformatf("to_nodone%0d", i), 32'(data_done), 32'd0);
      tick();
    end
    check("to_strobe_drop", 32'(bus_read),  32'd0);
    check("to_data_done",   32'(data_done), 32'd1);
    check("to_bus_error",   32'(bus_error), 32'd1);
    check("to_data_rdata",  data_rdata,     32'd0);
    data_req = 1'b0;
    tick();
    check("to_error_oneshot", 32'(bus_error), 32'd0);

    // Faulted data request ignored, concurrent fetch proceeds
    data_address = 32'h0000_3000; data_req = 1'b1; data_exp = 1'b1;
    inst_address = 32'h0000_00C0; inst_req = 1'b1;
    tick();
    check("exp_bus_address", bus_address,    32'h0000_00C0);
    check("exp_bus_read",    32'(bus_read),  32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_ack = 1'b0; inst_req = 1'b0;
    check("exp_inst_done",   32'(inst_done), 32'd1);
    check("exp_data_done",   32'(data_done), 32'd0);
    check("exp_inst_rdata",  inst_rdata,     32'h5555_AAAA);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("exp_nostrobe%0d", i), 32'({bus_read, bus_write}), 32'd0);
      check($sformatf("exp_nodone%0d", i),   32'(data_done),             32'd0);
    end
    data_req = 1'b0; data_exp = 1'b0;

    // Reset during ACC, late ack, then a normal access
    inst_address = 32'h0000_00D0; inst_req = 1'b1;
    tick();
    check("ra_bus_read", 32'(bus_read), 32'd1);
    rst = 1'b1;
    tick();
    check("ra_bus_read0",    32'(bus_read),  32'd0);
    check("ra_inst_done0",   32'(inst_done), 32'd0);
    check("ra_inst_rdata0",  inst_rdata,     32'd0);
    check("ra_bus_address0", bus_address,    32'd0);
    rst = 1'b0; inst_req = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0;
    check("ra_late_nodone", 32'(inst_done), 32'd0);
    check("ra_late_rdata",  inst_rdata,     32'd0);
    data_address = 32'h0000_00E0; data_req = 1'b1;
    tick();
    check("ra_new_read",    32'(bus_read), 32'd1);
    check("ra_new_address", bus_address,   32'h0000_00E0);
    bus_ack = 1'b1; bus_rdata = 32'h0000_BEEF;
    tick();
    bus_ack = 1'b0; data_req = 1'b0;
    check("ra_new_done",  32'(data_done), 32'd1);
    check("ra_new_rdata", data_rdata,     32'h0000_BEEF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
